parity_frame_tx: RTL and testbench

Serial framing stage directly downstream of the nibble parity generator. Accepts a DATA_W-bit word over a valid/ready handshake, computes its parity bit, and shifts out an asynchronous-style frame on a single line: start bit, data bits (LSB first), parity bit, stop bit. It is the transmit side of the parity link. The matching receiver/checker consumes `tx_out`.

---
 rtl/parity_pkg.sv | 32 +++
 rtl/parity_bit_timer.sv | 41 ++++
 rtl/parity_frame_tx.sv | 219 +++++++++++++++++++++
 tb/tb_parity_frame_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity link (transmit framer and receiver/checker).
//   ptx_state_t  : framer FSM states
//   LINE_IDLE / START_BIT / STOP_BIT : serial line levels
//   calc_parity  : parity of a zero-padded word; even (odd=0) or odd (odd=1)
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ptx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Widest payload supported by the link; narrower words are zero-padded,
    // which leaves their parity unchanged.
    localparam int PARITY_MAX_W = 16;

    // Even parity: ^data. Odd parity: ~^data.
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                         input logic                    odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_bit_timer.sv
// -----------------------------------------------------------------------------
// parity_bit_timer
// Modulo-CLKS_PER_BIT cycle counter marking serial bit boundaries.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart the count at 0 (frame start)
//   en        : count this cycle
//   count     : current position inside the bit, 0..CLKS_PER_BIT-1
//   bit_end   : high in the last cycle of a bit (count wraps on this edge)
// -----------------------------------------------------------------------------
module parity_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            en,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign count   = count_reg;
    assign bit_end = en && (count_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (en) begin
            if (count_reg == CNT_MAX) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
// Serial framer: accepts a DATA_W-bit word on a valid/ready handshake and
// sends start bit, data (LSB first), parity bit and stop bit on tx_out, each
// bit lasting CLKS_PER_BIT cycles.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : word to send, sampled on accept (in_valid && in_ready)
//   in_valid    : upstream has a word
//   in_ready    : framer can take a word
//   tx_out      : serial line, idles high
//   busy        : high while a frame is on the line
//   frame_done  : one-cycle pulse in the last cycle of the stop bit
// Build option PARITY_FRAME_TX_SKID_EN: adds a one-word holding register so
// a word can be taken while a frame is in flight, giving back-to-back frames.
// -----------------------------------------------------------------------------
module parity_frame_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);
    localparam logic             PAR_ODD    = (ODD_PARITY != 0);

    ptx_state_t         state_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic               parity_reg;
    logic [IDX_W-1:0]   bit_idx_reg;
    logic               tx_reg;
    logic               busy_reg;
    logic               frame_done_reg;

    logic [CNT_W-1:0]        bit_count;
    logic                    bit_end;
    logic                    accept;
    logic                    stop_end;
    logic                    frame_load;
    logic [DATA_W-1:0]       load_data;
    logic                    load_par;
    logic                    in_par;
    logic [PARITY_MAX_W-1:0] in_pad;
    logic [DATA_W-1:0]       shift_next;

    // Zero-pad the input word to the package parity width.
    genvar gi;
    generate
        for (gi = 0; gi < PARITY_MAX_W; gi++) begin : g_pad
            if (gi < DATA_W) begin : g_bit
                assign in_pad[gi] = in_data[gi];
            end else begin : g_zero
                assign in_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign in_par     = calc_parity(in_pad, PAR_ODD);
    assign accept     = in_valid && in_ready;
    assign stop_end   = (state_reg == ST_STOP) && bit_end;
    assign shift_next = shift_reg >> 1;

    assign tx_out     = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    parity_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (frame_load),
        .en      (state_reg != ST_IDLE),
        .count   (bit_count),
        .bit_end (bit_end)
    );

`ifdef PARITY_FRAME_TX_SKID_EN
    logic              hold_valid_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic              hold_par_reg;
    logic              direct_load;
    logic              hold_drain;

    assign in_ready = !rst && !hold_valid_reg;

    // A word goes straight into the shifter when the framer is about to start
    // a frame and nothing older is waiting; otherwise it parks in the holding
    // register until the current frame's stop bit ends.
    assign direct_load = accept && ((state_reg == ST_IDLE) || (stop_end && !hold_valid_reg));
    assign hold_drain  = stop_end && hold_valid_reg;

    always_comb begin
        frame_load = 1'b0;
        load_data  = in_data;
        load_par   = in_par;
        if (hold_drain) begin
            frame_load = 1'b1;
            load_data  = hold_data_reg;
            load_par   = hold_par_reg;
        end else if (direct_load) begin
            frame_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            hold_par_reg   <= 1'b0;
        end else if (accept && !direct_load) begin
            // Also covers accept during a drain: the new word takes the slot.
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= in_data;
            hold_par_reg   <= in_par;
        end else if (hold_drain) begin
            hold_valid_reg <= 1'b0;
        end
    end
`else
    assign in_ready = !rst && (state_reg == ST_IDLE);

    always_comb begin
        frame_load = (state_reg == ST_IDLE) && accept;
        load_data  = in_data;
        load_par   = in_par;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            bit_idx_reg    <= '0;
            tx_reg         <= LINE_IDLE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    tx_reg <= LINE_IDLE;
                    if (frame_load) begin
                        state_reg   <= ST_START;
                        shift_reg   <= load_data;
                        parity_reg  <= load_par;
                        bit_idx_reg <= '0;
                        tx_reg      <= START_BIT;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_reg <= ST_DATA;
                        tx_reg    <= shift_reg[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg   <= shift_next;
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        if (bit_idx_reg == IDX_LAST) begin
                            state_reg <= ST_PARITY;
                            tx_reg    <= parity_reg;
                        end else begin
                            tx_reg <= shift_next[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_reg <= ST_STOP;
                        tx_reg    <= STOP_BIT;
                    end
                end
                ST_STOP: begin
                    // Registered pulse: raise it one cycle early so it is
                    // visible during the final stop-bit cycle.
                    if (bit_count == CNT_PENULT) begin
                        frame_done_reg <= 1'b1;
                    end
                    if (bit_end) begin
                        if (frame_load) begin
                            state_reg   <= ST_START;
                            shift_reg   <= load_data;
                            parity_reg  <= load_par;
                            bit_idx_reg <= '0;
                            tx_reg      <= START_BIT;
                            busy_reg    <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            tx_reg    <= LINE_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= LINE_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_tx
// Directed bench for parity_frame_tx (DATA_W=4, CLKS_PER_BIT=4). Two
// instances: even parity (dut0) and odd parity (dut1). A table of words with
// hand-computed per-slot line levels drives single frames; hand-written
// sequences cover reset, idle, back-to-back streaming and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_parity_frame_tx;

`ifdef PARITY_FRAME_TX_SKID_EN
    localparam int   EXP_SPACING  = 28;
    localparam int   EXP_IDLE     = 0;
    localparam logic EXP_EARLY    = 1'b1;
    localparam logic EXP_TX_AFTER = 1'b0;
`else
    localparam int   EXP_SPACING  = 29;
    localparam int   EXP_IDLE     = 1;
    localparam logic EXP_EARLY    = 1'b0;
    localparam logic EXP_TX_AFTER = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       use_odd;
    logic       v0, v1;
    logic       rdy0, tx0, busy0, fd0;
    logic       rdy1, tx1, busy1, fd1;
    logic       rdy_s, tx_s, busy_s, fd_s;

    int n_pass  = 0;
    int n_check = 0;

    always #5 clk = ~clk;

    assign v0     = in_valid & ~use_odd;
    assign v1     = in_valid & use_odd;
    assign rdy_s  = use_odd ? rdy1  : rdy0;
    assign tx_s   = use_odd ? tx1   : tx0;
    assign busy_s = use_odd ? busy1 : busy0;
    assign fd_s   = use_odd ? fd1   : fd0;

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0),
        .in_ready(rdy0), .tx_out(tx0), .busy(busy0), .frame_done(fd0)
    );

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1),
        .in_ready(rdy1), .tx_out(tx1), .busy(busy1), .frame_done(fd1)
    );

    // slots: line level per 4-cycle slot, slot 0 (start) in the MSB.
    typedef struct {
        logic [3:0] data;
        logic       odd;
        logic [6:0] slots;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [6:0] slots;
        logic       exp_bit;
        logic       got;
        int         waited;
        int         busy_n;
        int         done_n;
        int         done_at;
        slots   = v.slots;
        use_odd = v.odd;
        @(negedge clk);
        in_data  = v.data;
        in_valid = 1'b1;
        waited   = 0;
        while (rdy_s !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d_ready", idx), rdy_s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        // Drop valid and scramble the data: the frame must not follow it.
        in_valid = 1'b0;
        in_data  = ~v.data;
        busy_n   = 0;
        done_n   = 0;
        done_at  = 0;
        for (int s = 0; s < 7; s++) begin
            exp_bit = slots[6-s];
            got     = exp_bit;
            for (int k = 0; k < 4; k++) begin
                if (tx_s !== exp_bit) got = tx_s;
                if (busy_s === 1'b1) busy_n++;
                if (fd_s === 1'b1) begin
                    done_n++;
                    done_at = s * 4 + k + 1;
                end
                @(negedge clk);
            end
            check($sformatf("v%0d_slot%0d", idx, s), got, exp_bit);
        end
        check($sformatf("v%0d_busy_cycles", idx), busy_n, 28);
        check($sformatf("v%0d_done_count", idx), done_n, 1);
        check($sformatf("v%0d_done_cycle", idx), done_at, 28);
        check($sformatf("v%0d_after_busy", idx), busy_s, 1'b0);
        check($sformatf("v%0d_after_tx", idx), tx_s, 1'b1);
        check($sformatf("v%0d_after_ready", idx), rdy_s, 1'b1);
    endtask

    // Back-to-back streaming bookkeeping
    int         done_q[$];
    int         acc_q[$];
    logic       busy_hist[120];
    logic       tx_hist[120];
    logic       rdy_hist[120];
    logic [3:0] words[4];

    task automatic run_stream();
        logic will_acc;
        int   wi;
        int   rdy_busy;
        int   idle_n;
        use_odd  = 1'b0;
        words[0] = 4'h3;
        words[1] = 4'hC;
        words[2] = 4'h5;
        words[3] = 4'hA;
        wi       = 0;
        rdy_busy = 0;
        @(negedge clk);
        in_data  = words[0];
        in_valid = 1'b1;
        will_acc = rdy_s;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (will_acc) begin
                acc_q.push_back(c);
                wi++;
                in_data = words[wi % 4];
            end
            if (fd_s === 1'b1) done_q.push_back(c);
            if (busy_s === 1'b1 && rdy_s === 1'b1) rdy_busy++;
            busy_hist[c] = busy_s;
            tx_hist[c]   = tx_s;
            rdy_hist[c]  = rdy_s;
            will_acc     = in_valid && rdy_s;
        end
        in_valid = 1'b0;
        repeat (80) @(negedge clk);

        check("stream_done_count_ge3", done_q.size() >= 3, 1'b1);
        check("stream_acc_count_ge2", acc_q.size() >= 2, 1'b1);
        if (done_q.size() >= 3 && acc_q.size() >= 2) begin
            check("stream_spacing_1_2", done_q[1] - done_q[0], EXP_SPACING);
            check("stream_spacing_2_3", done_q[2] - done_q[1], EXP_SPACING);
            idle_n = 0;
            for (int c = done_q[0] + 1; c < done_q[1]; c++) begin
                if (busy_hist[c] === 1'b0) idle_n++;
            end
            check("stream_idle_cycles", idle_n, EXP_IDLE);
            check("stream_tx_after_done", tx_hist[done_q[0] + 1], EXP_TX_AFTER);
            check("stream_ready_at_done", rdy_hist[done_q[0]], 1'b0);
            check("stream_second_accept_early", acc_q[1] < done_q[0], EXP_EARLY);
        end
`ifndef PARITY_FRAME_TX_SKID_EN
        check("stream_ready_while_busy", rdy_busy, 0);
`endif
    endtask

    task automatic run_mid_reset();
        int fd_n;
        int tx_low;
        int busy_n;
        use_odd = 1'b0;
        @(negedge clk);
        in_data  = 4'b1011;
        in_valid = 1'b1;
        check("rst_pre_ready", rdy_s, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        // Cycle 14 after accept: inside data bit 2 (0 for 4'b1011).
        check("rst_pre_bit2", tx_s, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", tx_s, 1'b1);
        check("rst_mid_busy", busy_s, 1'b0);
        check("rst_mid_ready", rdy_s, 1'b0);
        check("rst_mid_done", fd_s, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        fd_n   = 0;
        tx_low = 0;
        busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fd_s !== 1'b0) fd_n++;
            if (tx_s !== 1'b1) tx_low++;
            if (busy_s !== 1'b0) busy_n++;
        end
        check("rst_after_no_done", fd_n, 0);
        check("rst_after_line_high", tx_low, 0);
        check("rst_after_not_busy", busy_n, 0);
    endtask

    initial begin
        int tx_low;
        int busy_n;
        int fd_n;
        vecs[0] = '{4'b1011, 1'b0, 7'b0110111};
        vecs[1] = '{4'b0110, 1'b0, 7'b0011001};
        vecs[2] = '{4'b0000, 1'b1, 7'b0000011};
        vecs[3] = '{4'b0110, 1'b1, 7'b0011011};
        vecs[4] = '{4'b1111, 1'b0, 7'b0111101};
        vecs[5] = '{4'b1000, 1'b1, 7'b0000101};
        vecs[6] = '{4'b0001, 1'b0, 7'b0100011};
        vecs[7] = '{4'b1010, 1'b0, 7'b0010101};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        use_odd  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_tx", tx0, 1'b1);
        check("reset_ready", rdy0, 1'b0);
        check("reset_busy", busy0, 1'b0);
        check("reset_done", fd0, 1'b0);
        check("reset_tx_odd", tx1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_ready", rdy0, 1'b1);

        // Idle with in_valid low: line stays high, nothing happens.
        tx_low = 0;
        busy_n = 0;
        fd_n   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) tx_low++;
            if (busy0 !== 1'b0) busy_n++;
            if (fd0 !== 1'b0) fd_n++;
        end
        check("idle_line_high", tx_low, 0);
        check("idle_not_busy", busy_n, 0);
        check("idle_no_done", fd_n, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        run_stream();
        run_mid_reset();
        run_vec(vecs[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
